// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a big-endian 32-bit word stream into 512-bit
// FIPS 180-4 padded blocks (0x80 marker, zero fill, 64-bit bit-length).
module sha256_msg_padder #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned BLK_WORDS = 16,
  parameter int unsigned LEN_W     = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WORD_SIZE-1:0]           in_data,
  input  logic                           in_valid,
  input  logic                           in_last,
  input  logic [2:0]                     in_nbytes,
  output logic                           in_ready,
  output logic [BLK_WORDS*WORD_SIZE-1:0] blk_data,
  output logic                           blk_valid,
  output logic                           blk_first,
  output logic                           blk_last,
  input  logic                           blk_ready
);

  localparam int unsigned BC_W = LEN_W - 3;

  typedef enum logic [1:0] {FILL, OUT, PAD, LEN} state_t;

  state_t            state;
  logic [31:0]       words [16];
  logic [4:0]        idx;
  logic [BC_W-1:0]   bytecnt;
  logic [2:0]        nb_r;
  logic              pad_pend;
  logic              mark_pend;
  logic              first_pend;

  logic [2:0]        nb_eff;
  logic [31:0]       masked;
  logic [LEN_W-1:0]  bit_len;
  logic [31:0]       pad_w [16];
  logic [31:0]       len_w [16];
  logic [4:0]        pad_ni;
  logic              pad_miss;
  logic [3:0]        idx_m1;

  assign in_ready = (state == FILL) && rst_n;
  assign nb_eff   = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
  assign bit_len  = {bytecnt, 3'b000};
  assign idx_m1   = 4'(idx - 5'd1);

  always_comb begin
    masked = in_data;
    for (int unsigned j = 0; j < 4; j++) begin
      if (3'(j) >= nb_eff) masked[31-8*j -: 8] = 8'h00;
    end
  end

  always_comb begin
    blk_data = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      blk_data[511-32*i -: 32] = words[i];
    end
  end

  // Marker goes into the partial word if there is one, else into a fresh word;
  // a fresh word that falls off the block end is deferred to the length block.
  always_comb begin
    pad_w    = words;
    pad_ni   = idx;
    pad_miss = 1'b0;
    case (nb_r)
      3'd1: pad_w[idx_m1][23:16] = 8'h80;
      3'd2: pad_w[idx_m1][15:8]  = 8'h80;
      3'd3: pad_w[idx_m1][7:0]   = 8'h80;
      default: begin
        if (idx < 5'd16) begin
          pad_w[idx[3:0]] = 32'h8000_0000;
          pad_ni          = idx + 5'd1;
        end else begin
          pad_miss = 1'b1;
        end
      end
    endcase
    for (int unsigned i = 0; i < 16; i++) begin
      if (5'(i) >= pad_ni) pad_w[i] = '0;
    end
    if (pad_ni <= 5'd14) begin
      pad_w[14] = bit_len[63:32];
      pad_w[15] = bit_len[31:0];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) len_w[i] = '0;
    len_w[0]  = mark_pend ? 32'h8000_0000 : 32'h0000_0000;
    len_w[14] = bit_len[63:32];
    len_w[15] = bit_len[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      idx        <= '0;
      bytecnt    <= '0;
      nb_r       <= '0;
      pad_pend   <= 1'b0;
      mark_pend  <= 1'b0;
      first_pend <= 1'b1;
      blk_valid  <= 1'b0;
      blk_first  <= 1'b0;
      blk_last   <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) words[i] <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            if (in_last) begin
              words[idx[3:0]] <= masked;
              bytecnt         <= bytecnt + BC_W'(nb_eff);
              idx             <= idx + 5'(nb_eff != 3'd0);
              nb_r            <= nb_eff;
              state           <= PAD;
            end else begin
              words[idx[3:0]] <= in_data;
              bytecnt         <= bytecnt + BC_W'(4);
              idx             <= idx + 5'd1;
              if (idx == 5'd15) begin
                state     <= OUT;
                blk_valid <= 1'b1;
                blk_first <= first_pend;
                blk_last  <= 1'b0;
              end
            end
          end
        end
        PAD: begin
          words     <= pad_w;
          idx       <= pad_ni;
          state     <= OUT;
          blk_valid <= 1'b1;
          blk_first <= first_pend;
          if (pad_ni <= 5'd14) begin
            blk_last <= 1'b1;
          end else begin
            blk_last  <= 1'b0;
            pad_pend  <= 1'b1;
            mark_pend <= pad_miss;
          end
        end
        OUT: begin
          if (blk_ready) begin
            blk_valid  <= 1'b0;
            blk_first  <= 1'b0;
            blk_last   <= 1'b0;
            first_pend <= 1'b0;
            if (pad_pend) begin
              pad_pend <= 1'b0;
              state    <= LEN;
            end else begin
              if (blk_last) begin
                bytecnt    <= '0;
                first_pend <= 1'b1;
              end
              idx   <= '0;
              state <= FILL;
            end
          end
        end
        LEN: begin
          words     <= len_w;
          mark_pend <= 1'b0;
          state     <= OUT;
          blk_valid <= 1'b1;
          blk_first <= first_pend;
          blk_last  <= 1'b1;
        end
        default: state <= FILL;
      endcase
    end
  end

  a_nbytes_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && in_ready && in_last) |-> (in_nbytes <= 3'd4));

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: directed messages push hand-computed
// blocks; a monitor pops and compares on every block handshake.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_first;
  logic         blk_last;
  logic         blk_ready;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [511:0] d;
    logic         f;
    logic         l;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;

  sha256_msg_padder #(.WORD_SIZE(32), .BLK_WORDS(16), .LEN_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .blk_ready (blk_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(4 * i + 1);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  function automatic logic [511:0] setw(input logic [511:0] blk, input int i, input logic [31:0] w);
    blk[511-32*i -: 32] = w;
    return blk;
  endfunction

  task automatic push(input logic [511:0] d, input logic f, input logic l);
    exp_t e;
    e.d = d; e.f = f; e.l = l;
    sb.push_back(e);
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int n;
    n = 0;
    in_data = d; in_last = last; in_nbytes = nb; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_pat(input int nfull, input logic [31:0] lastw, input logic [2:0] nb);
    for (int i = 0; i < nfull; i++) send_word(pat(i), 1'b0, 3'd0);
    send_word(lastw, 1'b1, nb);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!blk_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!blk_valid) begin
      checks++;
      failures++;
      $display("FAIL blk_valid_timeout actual=0 required=1");
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && blk_valid && blk_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_block actual=%h required=none", blk_data);
      end else begin
        mon_e = sb.pop_front();
        chk("blk_data", blk_data, mon_e.d);
        chk("blk_first", 512'(blk_first), 512'(mon_e.f));
        chk("blk_last", 512'(blk_last), 512'(mon_e.l));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0] b;
    logic [511:0] abc;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    in_nbytes = '0; blk_ready = 1'b1;
    abc = setw(setw('0, 0, 32'h6162_6380), 15, 32'h0000_0018);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_blk_valid", 512'(blk_valid), 512'(0));
    chk("rst_blk_first", 512'(blk_first), 512'(0));
    chk("rst_blk_last", 512'(blk_last), 512'(0));
    chk("rst_blk_data", blk_data, '0);
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", 512'(in_ready), 512'(1));

    push(abc, 1'b1, 1'b1);
    send_word(32'h6162_6300, 1'b1, 3'd3);

    push(setw('0, 0, 32'h8000_0000), 1'b1, 1'b1);
    send_word(32'hDEAD_BEEF, 1'b1, 3'd0);

    b = setw(setw(setw('0, 0, 32'h0102_0304), 1, 32'h0506_8000), 15, 32'h0000_0030);
    push(b, 1'b1, 1'b1);
    send_pat(1, pat(1), 3'd2);

    b = setw(setw(setw(setw('0, 0, pat(0)), 1, pat(1)), 2, 32'h8000_0000), 15, 32'h0000_0040);
    push(b, 1'b1, 1'b1);
    send_pat(2, 32'hFFFF_FFFF, 3'd0);

    b = '0;
    for (int i = 0; i < 13; i++) b = setw(b, i, pat(i));
    b = setw(setw(b, 13, 32'h3536_3780), 15, 32'h0000_01B8);
    push(b, 1'b1, 1'b1);
    send_pat(13, pat(13), 3'd3);

    b = '0;
    for (int i = 0; i < 14; i++) b = setw(b, i, pat(i));
    b = setw(b, 14, 32'h8000_0000);
    push(b, 1'b1, 1'b0);
    push(setw('0, 15, 32'h0000_01C0), 1'b0, 1'b1);
    send_pat(13, pat(13), 3'd4);

    b = '0;
    for (int i = 0; i < 16; i++) b = setw(b, i, pat(i));
    push(b, 1'b1, 1'b0);
    push(setw(setw('0, 0, 32'h8000_0000), 15, 32'h0000_0200), 1'b0, 1'b1);
    send_pat(15, pat(15), 3'd4);

    // Backpressure: block must hold steady and input stays blocked.
    wait (sb.size() == 0 || $time > 400000);
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    push(abc, 1'b1, 1'b1);
    send_word(32'h6162_6300, 1'b1, 3'd3);
    wait_valid();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_blk_data", blk_data, abc);
      chk("stall_blk_valid", 512'(blk_valid), 512'(1));
      chk("stall_flags", 512'({blk_first, blk_last}), 512'(2'b11));
      chk("stall_in_ready", 512'(in_ready), 512'(0));
    end
    @(posedge clk);
    #1;
    blk_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset while a block is presented.
    blk_ready = 1'b0;
    send_word(32'h0102_0300, 1'b1, 3'd2);
    wait_valid();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_out_blk_valid", 512'(blk_valid), 512'(0));
    chk("rst_out_blk_first", 512'(blk_first), 512'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    blk_ready = 1'b1;

    // Reset mid-message, then a clean "abc".
    for (int i = 0; i < 5; i++) send_word(pat(i), 1'b0, 3'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_blk_valid", 512'(blk_valid), 512'(0));
    chk("rst_mid_in_ready", 512'(in_ready), 512'(0));
    chk("rst_mid_blk_data", blk_data, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(abc, 1'b1, 1'b1);
    send_word(32'h6162_6300, 1'b1, 3'd3);

    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    chk("sb_drain", 512'(sb.size()), 512'(0));
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
